// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and the write-back entry type
package regfile_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry;
   typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LD} wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order load-result buffer with wrapping pointers and occupancy count
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic    HCLK,
   input  logic    HRESET,
   input  logic    push,
   input  logic    pop,
   input  wb_entry din,
   output wb_entry dout,
   output logic    full,
   output logic    empty,
   output logic [AW:0] count
);
   wb_entry mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign dout  = mem[rd_ptr];
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   always_ff @(posedge HCLK or posedge HRESET)
      if (HRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   // storage needs no reset: entries are only read once count says they are valid
   always_ff @(posedge HCLK)
      if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: ALU/load write-back arbiter with registered RF write port; RF_WB_FWD_EN adds forwarding
module rf_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int LD_DEPTH = 2
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   output logic              alu_ready,
   input  logic              ld_valid,
   input  logic [REG_AW-1:0] ld_rd,
   input  logic [XLEN-1:0]   ld_data,
   output logic              ld_ready,
   output logic              WR,
   output logic [REG_AW-1:0] RW,
   output logic [XLEN-1:0]   DW,
`ifdef RF_WB_FWD_EN
   input  logic [REG_AW-1:0] RA,
   input  logic [REG_AW-1:0] RB,
   output logic              fwd_a_hit,
   output logic [XLEN-1:0]   fwd_a_data,
   output logic              fwd_b_hit,
   output logic [XLEN-1:0]   fwd_b_data,
`endif
   output logic [$clog2(LD_DEPTH):0] ld_count
);
   logic    full, empty, push, pop;
   wb_entry head, alu_e, sel;
   wb_src_e src;
   assign ld_ready  = !full;
   assign alu_ready = !full;
   assign push      = ld_valid && ld_ready;
   assign alu_e     = '{rd: alu_rd, data: alu_data};
   // a full FIFO preempts the ALU so loads cannot starve indefinitely
   always_comb begin
      src = full ? SRC_LD : alu_valid ? SRC_ALU : !empty ? SRC_LD : SRC_NONE;
      sel = (src == SRC_ALU) ? alu_e : head;
      pop = src == SRC_LD;
   end
   wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .push   (push),
      .pop    (pop),
      .din    ('{rd: ld_rd, data: ld_data}),
      .dout   (head),
      .full   (full),
      .empty  (empty),
      .count  (ld_count)
   );
   always_ff @(posedge HCLK or posedge HRESET)
      if (HRESET) begin
         WR <= 1'b0;
         RW <= '0;
         DW <= '0;
      end else begin
         WR <= (src != SRC_NONE) && (sel.rd != '0);
         if (src != SRC_NONE) begin
            RW <= sel.rd;
            DW <= sel.data;
         end
      end
`ifdef RF_WB_FWD_EN
   assign fwd_a_hit  = WR && (RW == RA) && (RA != '0);
   assign fwd_a_data = fwd_a_hit ? DW : '0;
   assign fwd_b_hit  = WR && (RW == RB) && (RB != '0);
   assign fwd_b_data = fwd_b_hit ? DW : '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: randomized scoreboard bench for rf_wb_arbiter against a queue-based model
module tb_rf_wb_arbiter;
   import regfile_pkg::*;
   localparam int D = 2;
   logic HCLK = 0, HRESET = 1;
   logic alu_valid = 0, ld_valid = 0, alu_ready, ld_ready, WR;
   logic [4:0] alu_rd = 0, ld_rd = 0, RW, RA = 0, RB = 0;
   logic [31:0] alu_data = 0, ld_data = 0, DW;
   logic [$clog2(D):0] ld_count;
`ifdef RF_WB_FWD_EN
   logic fwd_a_hit, fwd_b_hit;
   logic [31:0] fwd_a_data, fwd_b_data;
`endif
   always #5 HCLK = ~HCLK;
   rf_wb_arbiter #(.LD_DEPTH(D)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .WR(WR), .RW(RW), .DW(DW),
`ifdef RF_WB_FWD_EN
      .RA(RA), .RB(RB), .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
      .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
`endif
      .ld_count(ld_count)
   );
   typedef struct {logic [4:0] rd; logic [31:0] data; int due;} exp_t;
   exp_t exp_q[$];
   wb_entry mq[$];
   int checks = 0, failures = 0, cyc = 0, ra_ovr = -1, rb_ovr = -1;
   logic [4:0] last_rd = 0;
   always @(posedge HCLK) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
      end
   endtask
   // monitor: every write must match the oldest expected entry in content and cycle
   always @(negedge HCLK) begin
      exp_t e;
      bit ew, ha, hb;
      e = '{0, 0, 0};
      ew = exp_q.size() > 0 && exp_q[0].due == cyc;
      chk("wr", WR, ew);
      if (ew) begin
         e = exp_q.pop_front();
         chk("rw", RW, e.rd);
         chk("dw", DW, e.data);
      end
      ha = ew && e.rd == RA && RA != 0;
      hb = ew && e.rd == RB && RB != 0;
`ifdef RF_WB_FWD_EN
      chk("fwd_a_hit", fwd_a_hit, ha);
      chk("fwd_a_data", fwd_a_data, ha ? e.data : 0);
      chk("fwd_b_hit", fwd_b_hit, hb);
      chk("fwd_b_data", fwd_b_data, hb ? e.data : 0);
`endif
   end
   task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ldd,
                       output bit aa, output bit la);
      int n;
      wb_entry e;
      bit s;
      @(posedge HCLK); #1;
      n = mq.size();
      chk("ld_ready", ld_ready, n < D);
      chk("alu_ready", alu_ready, n != D);
      chk("ld_count", ld_count, n);
      alu_valid = av; alu_rd = ar; alu_data = ad;
      ld_valid = lv; ld_rd = lr; ld_data = ldd;
      RA = ra_ovr >= 0 ? 5'(ra_ovr) : ($urandom_range(0, 1) == 1 ? last_rd : 5'($urandom_range(0, 31)));
      RB = rb_ovr >= 0 ? 5'(rb_ovr) : ($urandom_range(0, 3) == 0 ? last_rd : 5'($urandom_range(0, 31)));
      aa = av && n != D;
      la = lv && n < D;
      if (av && ar != 0) begin
         assert (!(lv && lr == ar)) else $error("rd hazard alu/load rd=%0d", ar);
         foreach (mq[i]) assert (mq[i].rd != ar) else $error("rd hazard queued rd=%0d", ar);
      end
      s = 1; e = '0;
      if (n == D) e = mq.pop_front();
      else if (av) e = '{ar, ad};
      else if (n > 0) e = mq.pop_front();
      else s = 0;
      last_rd = s ? e.rd : 5'($urandom_range(0, 31));
      if (s && e.rd != 0) exp_q.push_back('{e.rd, e.data, cyc + 1});
      if (la) mq.push_back('{lr, ldd});
   endtask
   task automatic do_reset();
      @(posedge HCLK); #1;
      alu_valid = 0; ld_valid = 0;
      #2 HRESET = 1;
      exp_q.delete(); mq.delete();
      #1;
      chk("rst_wr", WR, 0);
      chk("rst_count", ld_count, 0);
      chk("rst_ld_ready", ld_ready, 1);
      chk("rst_alu_ready", alu_ready, 1);
      @(negedge HCLK); #2 HRESET = 0;
   endtask
   task automatic idle(input int k);
      bit aa, la;
      repeat (k) step(0, 0, 0, 0, 0, 0, aa, la);
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      bit aa, la, apv, lpv;
      logic [4:0] apr, lpr;
      logic [31:0] apd, lpd;
      logic [4:0] rds [3];
      int i, k;
      rds = '{5'd7, 5'd8, 5'd9};
      apv = 0; lpv = 0; apr = 0; lpr = 0; apd = 0; lpd = 0;
      #12;
      chk("init_wr", WR, 0);
      chk("init_count", ld_count, 0);
      chk("init_ld_ready", ld_ready, 1);
      chk("init_alu_ready", alu_ready, 1);
      @(negedge HCLK); #2 HRESET = 0;
      step(1, 5, 32'hDEADBEEF, 0, 0, 0, aa, la);
      idle(2);
      step(1, 0, 32'h12345678, 0, 0, 0, aa, la);
      chk("x0_alu_acc", alu_ready, 1);
      idle(2);
      step(1, 10, 32'hA5A5A5A5, 0, 0, 0, aa, la);
      ra_ovr = 10; rb_ovr = 0;
      idle(1);
      ra_ovr = -1; rb_ovr = -1;
      idle(1);
      i = 0; k = 0;
      while (i < 3 && k < 20) begin
         step(1, 3, 32'(k), 1, rds[i], 32'(i + 1), aa, la);
         if (la) i++;
         k++;
      end
      chk("starve_loads_taken", 32'(i), 3);
      idle(4);
      i = 0; k = 0;
      while (i < 8 && k < 40) begin
         step(k < 3, 5'(k + 1), 32'(100 + k), 1, 5'(16 + i), 32'(i), aa, la);
         if (la) i++;
         k++;
      end
      chk("wrap_loads_taken", 32'(i), 8);
      idle(4);
      step(1, 1, 32'h11, 1, 20, 32'h20, aa, la);
      step(1, 2, 32'h22, 1, 21, 32'h21, aa, la);
      do_reset();
      idle(4);
      repeat (400) begin
         if (!apv && $urandom_range(0, 2) != 0) begin
            apv = 1; apr = 5'($urandom_range(0, 15)); apd = $urandom;
         end
         if (!lpv && $urandom_range(0, 1) == 1) begin
            lpv = 1; lpr = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(16, 31)); lpd = $urandom;
         end
         step(apv, apr, apd, lpv, lpr, lpd, aa, la);
         if (aa) apv = 0;
         if (la) lpv = 0;
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
            apv = 0; lpv = 0;
         end
      end
      idle(D + 4);
      @(negedge HCLK); #1;
      chk("drain_empty", 64'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
